// File: rtl/snoop_responder.sv
// Snoop agent for one core of the dual-core MSI system: invalidates, cache-to-cache supply of M blocks, bus passthrough.
// Define SNOOP_STATS_EN to add the saturating snoop_hits / snoop_invs counters.
module snoop_responder #(
    parameter  int IDX_W = 4,
    localparam int TAG_W = 32 - IDX_W - 3
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ccwait,
    input  logic             ccinv,
    input  logic [31:0]      ccsnoopaddr,
    input  logic             ccack,
    input  logic             req_ccwrite,
    input  logic [31:0]      req_dstore,
    output logic             ccwrite,
    output logic [31:0]      dstore,
    output logic [IDX_W-1:0] snoop_idx,
    input  logic [TAG_W-1:0] frame_tag,
    input  logic [1:0]       frame_state,
    input  logic [31:0]      frame_word0,
    input  logic [31:0]      frame_word1,
    output logic             st_wen,
    output logic [IDX_W-1:0] st_idx,
    output logic [1:0]       st_next,
    output logic             snoop_busy
`ifdef SNOOP_STATS_EN
    ,
    output logic [15:0]      snoop_hits,
    output logic [15:0]      snoop_invs
`endif
);

    typedef enum logic [2:0] {IDLE, ARM, SNOOP, SUPPLY, DONE} state_t;

    localparam logic [1:0] MSI_I = 2'd0;
    localparam logic [1:0] MSI_S = 2'd1;
    localparam logic [1:0] MSI_M = 2'd2;

    state_t           state_q, state_d;
    logic             wcnt_q, wcnt_d;
    logic [IDX_W-1:0] sup_idx_q, sup_idx_d;

    logic [IDX_W-1:0] addr_idx;
    logic [TAG_W-1:0] addr_tag;
    logic             hit;
    logic             hit_m;
    logic             unused_addr_bits;

    assign addr_idx         = ccsnoopaddr[IDX_W+2:3];
    assign addr_tag         = ccsnoopaddr[31:IDX_W+3];
    assign unused_addr_bits = ^ccsnoopaddr[2:0];

    // State 3 is not in {S, M}, so it never hits and behaves as I.
    assign hit   = (frame_tag == addr_tag) && ((frame_state == MSI_S) || (frame_state == MSI_M));
    assign hit_m = hit && (frame_state == MSI_M);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            wcnt_q    <= 1'b0;
            sup_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            sup_idx_q <= sup_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        sup_idx_d = sup_idx_q;
        if ((state_q != IDLE) && !ccwait) begin
            // Controller withdrew the snoop: abandon it without touching the frame state.
            state_d = IDLE;
            wcnt_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE:   if (ccwait) state_d = ARM;
                ARM:    state_d = SNOOP;
                SNOOP: begin
                    if (!ccinv && hit_m) begin
                        state_d   = SUPPLY;
                        sup_idx_d = addr_idx;
                        if (ccack) wcnt_d = wcnt_q + 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
                SUPPLY: begin
                    if (ccack) begin
                        if (wcnt_q) begin
                            wcnt_d  = 1'b0;
                            state_d = DONE;
                        end else begin
                            wcnt_d = 1'b1;
                        end
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ccwrite    = 1'b0;
        dstore     = '0;
        snoop_idx  = addr_idx;
        st_wen     = 1'b0;
        st_idx     = addr_idx;
        st_next    = MSI_I;
        snoop_busy = 1'b1;
        case (state_q)
            IDLE: begin
                ccwrite    = req_ccwrite;
                dstore     = req_dstore;
                snoop_busy = 1'b0;
            end
            SNOOP: begin
                if (ccinv) begin
                    st_wen = hit && ccwait;
                end else if (hit_m) begin
                    ccwrite = 1'b1;
                    dstore  = wcnt_q ? frame_word1 : frame_word0;
                end
            end
            SUPPLY: begin
                // The frame is read from the latched index; ccsnoopaddr may move on.
                snoop_idx = sup_idx_q;
                st_idx    = sup_idx_q;
                ccwrite   = 1'b1;
                dstore    = wcnt_q ? frame_word1 : frame_word0;
                if (ccack && wcnt_q && ccwait) begin
                    st_wen  = 1'b1;
                    st_next = MSI_S;
                end
            end
            default: ;
        endcase
    end

`ifdef SNOOP_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] snoop_hits_q, snoop_hits_d;
    logic [15:0] snoop_invs_q, snoop_invs_d;

    always_comb begin
        snoop_hits_d = snoop_hits_q;
        snoop_invs_d = snoop_invs_q;
        if (st_wen) begin
            if (st_next == MSI_S) snoop_hits_d = sat_inc16(snoop_hits_q);
            else                  snoop_invs_d = sat_inc16(snoop_invs_q);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            snoop_hits_q <= '0;
            snoop_invs_q <= '0;
        end else begin
            snoop_hits_q <= snoop_hits_d;
            snoop_invs_q <= snoop_invs_d;
        end
    end

    assign snoop_hits = snoop_hits_q;
    assign snoop_invs = snoop_invs_q;
`endif

endmodule
